mc_controller: RTL and testbench

Multi-cycle control unit for the 16-bit windowed-register CPU. It sits directly upstream of the windowed register file and owns the PC, the IR, the current window pointer and the main FSM. It sequences instruction-memory handshakes and drives the register-file address, window and write-enable lines, plus the ALU and writeback selects.

---
 rtl/cpu_ctrl_pkg.sv | 41 ++++
 rtl/instr_decoder.sv | 23 ++
 rtl/mc_controller.sv | 150 +++++++++++++++
 tb/tb_mc_controller.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the windowed-register CPU control unit.
// Opcodes, ALU function codes, FSM states and writeback selects.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_JUMP  = 3'd2,
    OP_BRZ   = 3'd3,
    OP_ALU   = 3'd4,
    OP_MOVR  = 3'd5,
    OP_WIN   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_NOTB  = 3'd5,
    ALU_PASSB = 3'd6,
    ALU_SHL1  = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_RD_WAIT    = 3'd2,
    S_MEM_RD     = 3'd3,
    S_MEM_WR     = 3'd4,
    S_WB         = 3'd5,
    S_WIN_SETTLE = 3'd6,
    S_HALT       = 3'd7
  } state_t;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction field extraction for the control unit.
// Splits IR into opcode class, ALU function, source register, address and window.
module instr_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W   = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  output opcode_t           opcode,
  output alu_op_t           func,
  output logic [1:0]        ri,
  output logic [PC_W-1:0]   addr,
  output logic [1:0]        win
);

  assign opcode = opcode_t'(ir[DATA_W-1 -: 3]);
  assign func   = alu_op_t'(ir[DATA_W-4 -: 3]);
  assign ri     = ir[DATA_W-7 -: 2];
  assign addr   = ir[PC_W-1:0];
  assign win    = ir[1:0];

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control unit: owns PC, IR, window pointer and the main FSM,
// sequencing memory handshakes and register-file / ALU control lines.
module mc_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W   = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              r0_zero,
  output logic [PC_W-1:0]   mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mdr_en,
  output logic [1:0]        window_out,
  output logic [1:0]        read_reg1,
  output logic [1:0]        read_reg2,
  output logic [1:0]        write_reg,
  output logic              reg_write_en,
  output logic [2:0]        alu_op,
  output logic              wb_sel,
  output logic              halted
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] ir;
  logic [1:0]        window;

  opcode_t           opcode;
  alu_op_t           func;
  logic [1:0]        ri;
  logic [PC_W-1:0]   addr;
  logic [1:0]        win;
  alu_op_t           ex_op;

  instr_decoder #(
    .PC_W  (PC_W),
    .DATA_W(DATA_W)
  ) u_dec (
    .ir    (ir),
    .opcode(opcode),
    .func  (func),
    .ri    (ri),
    .addr  (addr),
    .win   (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      window <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + PC_ONE;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_JUMP: begin
              pc    <= addr;
              state <= S_FETCH;
            end
            OP_LOAD: state <= S_MEM_RD;
            OP_WIN: begin
              window <= win;
              state  <= S_WIN_SETTLE;
            end
            OP_HALT: state <= S_HALT;
            default: state <= S_RD_WAIT;
          endcase
        end
        S_RD_WAIT: begin
          case (opcode)
            OP_STORE: state <= S_MEM_WR;
            OP_BRZ: begin
              if (r0_zero) pc <= addr;
              state <= S_FETCH;
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM_RD:     if (mem_ready) state <= S_WB;
        S_MEM_WR:     if (mem_ready) state <= S_FETCH;
        S_WB:         state <= S_FETCH;
        S_WIN_SETTLE: state <= S_FETCH;
        S_HALT:       state <= S_HALT;
        default:      state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ex_op = ALU_ADD;
    if (opcode == OP_ALU)       ex_op = func;
    else if (opcode == OP_MOVR) ex_op = ALU_PASSB;
  end

  assign window_out = window;
  assign write_reg  = 2'b00;
  assign read_reg1  = 2'b00;

  // Reset parks the FSM in FETCH, so gating the fetch request with rst is
  // what makes every output read zero while reset is held.
  always_comb begin
    mem_addr     = addr;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mdr_en       = 1'b0;
    read_reg2    = 2'b00;
    reg_write_en = 1'b0;
    alu_op       = 3'(ALU_ADD);
    wb_sel       = WB_ALU;
    halted       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_addr = pc;
        mem_rd   = ~rst;
      end
      S_DECODE, S_RD_WAIT: begin
        if (opcode == OP_ALU || opcode == OP_MOVR) read_reg2 = ri;
        if (state == S_RD_WAIT) alu_op = 3'(ex_op);
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        mdr_en = mem_ready;
      end
      S_MEM_WR: mem_wr = 1'b1;
      S_WB: begin
        reg_write_en = 1'b1;
        wb_sel       = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
        alu_op       = 3'(ex_op);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: table of instructions expanded into
// per-cycle expectations on a scoreboard, plus hand-written reset sequences.
module tb_mc_controller;

  localparam int unsigned PC_W   = 12;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              r0_zero;
  logic [PC_W-1:0]   mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              mdr_en;
  logic [1:0]        window_out;
  logic [1:0]        read_reg1;
  logic [1:0]        read_reg2;
  logic [1:0]        write_reg;
  logic              reg_write_en;
  logic [2:0]        alu_op;
  logic              wb_sel;
  logic              halted;

  mc_controller #(
    .PC_W  (PC_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .r0_zero     (r0_zero),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mdr_en      (mdr_en),
    .window_out  (window_out),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .write_reg   (write_reg),
    .reg_write_en(reg_write_en),
    .alu_op      (alu_op),
    .wb_sel      (wb_sel),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic        rd;
    logic        wr;
    logic        mdr;
    logic [1:0]  win;
    logic [1:0]  rr1;
    logic [1:0]  rr2;
    logic [1:0]  wreg;
    logic        we;
    logic [2:0]  alu;
    logic        wbs;
    logic        halted;
  } exp_t;

  typedef struct {
    logic [15:0] ir;
    int unsigned flat;
    int unsigned mlat;
    logic        r0z;
    logic [1:0]  rr1;
    logic [1:0]  rr2;
    logic [2:0]  alu;
    logic        wbs;
    logic [1:0]  win;
    logic [11:0] npc;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[17];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          step     = 0;
  logic [11:0] pc_m;
  logic [1:0]  win_m;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, got, want);
    end
  endtask

  task automatic compare_next();
    exp_t e;
    step++;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard step %0d: got empty queue expected an entry", step);
    end else begin
      e = sb.pop_front();
      chk("mem_addr",     16'(mem_addr),     16'(e.addr));
      chk("mem_rd",       16'(mem_rd),       16'(e.rd));
      chk("mem_wr",       16'(mem_wr),       16'(e.wr));
      chk("mdr_en",       16'(mdr_en),       16'(e.mdr));
      chk("window_out",   16'(window_out),   16'(e.win));
      chk("read_reg1",    16'(read_reg1),    16'(e.rr1));
      chk("read_reg2",    16'(read_reg2),    16'(e.rr2));
      chk("write_reg",    16'(write_reg),    16'(e.wreg));
      chk("reg_write_en", 16'(reg_write_en), 16'(e.we));
      chk("alu_op",       16'(alu_op),       16'(e.alu));
      chk("wb_sel",       16'(wb_sel),       16'(e.wbs));
      chk("halted",       16'(halted),       16'(e.halted));
    end
  endtask

  function automatic exp_t blank(input logic [11:0] a);
    exp_t e;
    e      = '0;
    e.addr = a;
    e.win  = win_m;
    return e;
  endfunction

  function automatic vec_t mk(input logic [15:0] ir, input int unsigned flat, input int unsigned mlat,
                              input logic r0z, input logic [1:0] rr1, input logic [1:0] rr2,
                              input logic [2:0] alu, input logic wbs, input logic [1:0] win,
                              input logic [11:0] npc);
    vec_t v;
    v.ir = ir; v.flat = flat; v.mlat = mlat; v.r0z = r0z; v.rr1 = rr1; v.rr2 = rr2;
    v.alu = alu; v.wbs = wbs; v.win = win; v.npc = npc;
    return v;
  endfunction

  // One clock: drive inputs, queue the expectation, compare on the falling edge.
  task automatic cyc(input logic [15:0] rdata, input logic rdy, input logic r0z, input exp_t e);
    mem_rdata = rdata;
    mem_ready = rdy;
    r0_zero   = r0z;
    sb.push_back(e);
    @(negedge clk);
    compare_next();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input exp_t e);
    sb.push_back(e);
    compare_next();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    pc_m  = '0;
    win_m = '0;
    check_now(blank(12'h000));
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    logic [2:0]  op;
    logic [11:0] a;
    op = v.ir[15:13];
    a  = v.ir[11:0];
    for (int unsigned i = 0; i < v.flat; i++) begin
      e = blank(pc_m); e.rd = 1'b1;
      cyc(16'h0000, 1'b0, 1'b0, e);
    end
    e = blank(pc_m); e.rd = 1'b1;
    cyc(v.ir, 1'b1, 1'b0, e);
    e = blank(a); e.rr1 = v.rr1; e.rr2 = v.rr2;
    cyc(16'h0000, 1'b0, 1'b0, e);
    case (op)
      3'd0: begin
        for (int unsigned i = 0; i < v.mlat; i++) begin
          e = blank(a); e.rd = 1'b1;
          cyc(16'h0000, 1'b0, 1'b0, e);
        end
        e = blank(a); e.rd = 1'b1; e.mdr = 1'b1;
        cyc(16'h5A5A, 1'b1, 1'b0, e);
        e = blank(a); e.we = 1'b1; e.wbs = v.wbs;
        cyc(16'h0000, 1'b0, 1'b0, e);
      end
      3'd1: begin
        e = blank(a); e.rr1 = v.rr1;
        cyc(16'h0000, 1'b0, 1'b0, e);
        for (int unsigned i = 0; i < v.mlat; i++) begin
          e = blank(a); e.wr = 1'b1;
          cyc(16'h0000, 1'b0, 1'b0, e);
        end
        e = blank(a); e.wr = 1'b1;
        cyc(16'h0000, 1'b1, 1'b0, e);
      end
      3'd3: begin
        e = blank(a); e.rr1 = v.rr1;
        cyc(16'h0000, 1'b0, v.r0z, e);
      end
      3'd4, 3'd5: begin
        e = blank(a); e.rr1 = v.rr1; e.rr2 = v.rr2; e.alu = v.alu;
        cyc(16'h0000, 1'b0, 1'b0, e);
        e = blank(a); e.we = 1'b1; e.alu = v.alu; e.wbs = v.wbs;
        cyc(16'h0000, 1'b0, 1'b0, e);
      end
      3'd6: begin
        win_m = v.win;
        e = blank(a);
        cyc(16'h0000, 1'b1, 1'b0, e);
      end
      3'd7: begin
        for (int unsigned i = 0; i < 3; i++) begin
          e = blank(a); e.halted = 1'b1;
          cyc(16'hFFFF, 1'b1, 1'b1, e);
        end
      end
      default: ;
    endcase
    pc_m  = v.npc;
    win_m = v.win;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1);
  end

  initial begin
    exp_t e;
    //            ir        flat mlat r0z rr1 rr2 alu  wbs win  npc
    vt[0]  = mk(16'h0010, 0, 2, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 2'd0, 12'h001); // LOAD 0x010
    vt[1]  = mk(16'h8500, 0, 0, 1'b0, 2'd0, 2'd1, 3'd1, 1'b0, 2'd0, 12'h002); // SUB R1
    vt[2]  = mk(16'hA300, 1, 0, 1'b0, 2'd0, 2'd3, 3'd6, 1'b0, 2'd0, 12'h003); // MOVR R3
    vt[3]  = mk(16'h9200, 0, 0, 1'b0, 2'd0, 2'd2, 3'd4, 1'b0, 2'd0, 12'h004); // XOR R2
    vt[4]  = mk(16'h2055, 0, 1, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 2'd0, 12'h005); // STORE 0x055
    vt[5]  = mk(16'h60AB, 0, 0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 2'd0, 12'h006); // BRZ not taken
    vt[6]  = mk(16'h60AB, 2, 0, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0, 2'd0, 12'h0AB); // BRZ taken
    vt[7]  = mk(16'hC002, 0, 0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 2'd2, 12'h0AC); // WIN 2
    vt[8]  = mk(16'hC002, 0, 0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 2'd2, 12'h0AD); // WIN 2 again
    vt[9]  = mk(16'h9C00, 0, 0, 1'b0, 2'd0, 2'd0, 3'd7, 1'b0, 2'd2, 12'h0AE); // SHL1 R0
    vt[10] = mk(16'h4FFF, 0, 0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 2'd2, 12'hFFF); // JUMP 0xFFF
    vt[11] = mk(16'h60AB, 0, 0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 2'd2, 12'h000); // BRZ nt, pc wraps
    vt[12] = mk(16'h4FFF, 0, 0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 2'd2, 12'hFFF); // JUMP 0xFFF
    vt[13] = mk(16'h4123, 0, 0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 2'd2, 12'h123); // JUMP 0x123
    vt[14] = mk(16'h03FF, 0, 0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 2'd2, 12'h124); // LOAD zero-wait
    vt[15] = mk(16'h8D00, 0, 0, 1'b0, 2'd0, 2'd1, 3'd3, 1'b0, 2'd2, 12'h125); // OR R1
    vt[16] = mk(16'hE000, 0, 0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 2'd2, 12'h125); // HALT

    rst       = 1'b1;
    mem_rdata = '0;
    mem_ready = 1'b0;
    r0_zero   = 1'b0;
    pc_m      = '0;
    win_m     = '0;
    #2;
    check_now(blank(12'h000));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vt[i]) run_vec(vt[i]);

    // HALT is left only through reset
    pulse_reset();

    // Reset in the middle of a LOAD: request drops, window clears, no writeback
    run_vec(mk(16'hC003, 0, 0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 2'd3, 12'h001));
    e = blank(12'h001); e.rd = 1'b1;
    cyc(16'h00AA, 1'b1, 1'b0, e);
    e = blank(12'h0AA);
    cyc(16'h0000, 1'b0, 1'b0, e);
    e = blank(12'h0AA); e.rd = 1'b1;
    cyc(16'h0000, 1'b0, 1'b0, e);
    pulse_reset();

    // Reset while a fetch is still waiting for memory
    e = blank(12'h000); e.rd = 1'b1;
    cyc(16'hE000, 1'b0, 1'b0, e);
    pulse_reset();

    run_vec(mk(16'hA100, 0, 0, 1'b0, 2'd0, 2'd1, 3'd6, 1'b0, 2'd0, 12'h001));
    e = blank(pc_m); e.rd = 1'b1;
    cyc(16'h0000, 1'b0, 1'b0, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
